led_bank_arbiter: RTL and testbench
===================================

LED_BANK_ARBITER -- requirements
Module: led_bank_arbiter

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 50000000, giving the time-slice length in clk cycles (legal range 2..2^26-1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 3 bits: requester i asks for the LED bank while req[i]=1.
REQ-005 The block SHALL have ports pattern0, pattern1 and pattern2, each input, 5 bits: LED pattern of requester 0/1/2.
REQ-006 The block SHALL have port skip_re, input, 1 bit: one-cycle pulse (button rising edge) forcing hand-over.
REQ-007 The block SHALL have port grant, output, 3 bits: one-hot or zero, the current owner of the LED bank.
REQ-008 The block SHALL have port led, output, 5 bits, registered: the LED bank drive.
REQ-009 The block SHALL have port busy, output, 1 bit: 1 in GRANT state, else 0.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT and SWITCH.
REQ-011 In IDLE, grant=0 and led=0; when any req bit is sampled 1, the next state SHALL be GRANT with grant and led valid one clock later.
REQ-012 The winner SHALL be chosen round-robin: search order last_owner+1, +2, +3 (mod 3); last_owner is a 2-bit register.
REQ-013 On entering GRANT, last_owner SHALL load the winner index and the 26-bit dwell counter SHALL load 0.
REQ-014 In GRANT, led SHALL load pattern of the owner every cycle (1-cycle latency from pattern change to led).
REQ-015 In GRANT, the dwell counter SHALL increment each cycle; at DWELL_CYCLES-1 it SHALL wrap to 0.
REQ-016 GRANT SHALL go to SWITCH when req[owner] is sampled 0.
REQ-017 GRANT SHALL go to SWITCH when the counter equals DWELL_CYCLES-1 and another req bit is 1.
REQ-018 GRANT SHALL go to SWITCH when skip_re=1 and another req bit is 1.
REQ-019 With counter wrap or skip_re and no other requester, the block SHALL stay in GRANT, the counter wrapping or staying unaffected respectively.
REQ-020 Simultaneous exit causes (REQ-016..018) SHALL produce a single SWITCH; skip_re outside GRANT SHALL be ignored.
REQ-021 SWITCH SHALL last exactly one cycle with grant=0 and led=0 (blanking), then go to GRANT if any req bit is 1, else IDLE.
REQ-022 The winner after SWITCH SHALL exclude nobody: the old owner wins again only if no other requester is pending.
REQ-023 A requester SHALL never receive more than DWELL_CYCLES consecutive GRANT cycles while another req bit is held at 1.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, grant=0, led=0, busy=0, counter=0 and last_owner=2, regardless of the current state.
REQ-025 reset SHALL dominate all other inputs in the same cycle; after release, requester 0 SHALL win first if requested.

Configuration
REQ-026 Macro LED_BANK_ARBITER_PRIORITY_EN SHALL select the arbitration policy.
REQ-027 With LED_BANK_ARBITER_PRIORITY_EN defined, req[0] SHALL always win arbitration.
REQ-028 With LED_BANK_ARBITER_PRIORITY_EN defined, req[0]=1 while requester 1 or 2 owns the bank SHALL cause SWITCH on the next edge, ignoring the dwell count.
REQ-029 Without LED_BANK_ARBITER_PRIORITY_EN, arbitration SHALL be pure round-robin per REQ-012, and no preemption logic SHALL be present.

Verification (DWELL_CYCLES=8)
REQ-030 Bench: reset, req=001, pattern0=10101 -> next cycle grant=001, led=10101, busy=1; held indefinitely, counter wraps, no SWITCH.
REQ-031 Bench: req=011 from IDLE after reset -> grant=001 for 8 cycles, 1 blank cycle (grant=000, led=00000), grant=010 for 8 cycles, repeat.
REQ-032 Bench: owner 1, drop req[1] with req=100 pending -> next cycle SWITCH, then grant=100; last_owner=2.
REQ-033 Bench: owner 0 with req=011, skip_re pulse at count 3 -> SWITCH next edge, grant=010 afterwards; skip_re with req=001 -> no change.
REQ-034 Bench: reset asserted mid-GRANT (owner 2) -> next cycle grant=000, led=00000, busy=0; after release with req=111, grant=001.
REQ-035 Bench (LED_BANK_ARBITER_PRIORITY_EN): owner 2 at count 1, raise req[0] -> SWITCH next edge, then grant=001; without macro, owner 2 keeps bank until count 7.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// Round-robin LED bank arbiter with time-sliced ownership and a one-cycle blanking hand-over.
// Define LED_BANK_ARBITER_PRIORITY_EN to make requester 0 always win and preempt the others.
module led_bank_arbiter #(
   parameter int unsigned DWELL_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic [4:0] pattern0,
   input  logic [4:0] pattern1,
   input  logic [4:0] pattern2,
   input  logic       skip_re,
   output logic [2:0] grant,
   output logic [4:0] led,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;

   localparam logic [25:0] COUNT_LAST = 26'(DWELL_CYCLES - 1);

   state_t      state;
   logic [1:0]  last_owner;
   logic [25:0] count;

   logic [1:0]  rr_winner;
   logic [1:0]  winner;
   logic [1:0]  cand;
   logic        found;
   logic [2:0]  owner_mask;
   logic [2:0]  others;
   logic [4:0]  owner_pattern;
   logic [4:0]  winner_pattern;
   logic        leave;

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

   function automatic logic [4:0] pick_pattern(input logic [1:0] idx, input logic [4:0] p0,
                                               input logic [4:0] p1, input logic [4:0] p2);
      case (idx)
         2'd1:    return p1;
         2'd2:    return p2;
         default: return p0;
      endcase
   endfunction

   // Search last_owner+1, +2, +3 (mod 3); the old owner is considered last.
   always_comb begin
      rr_winner = '0;
      cand      = '0;
      found     = 1'b0;
      for (int unsigned k = 1; k <= 3; k++) begin
         cand = 2'((32'(last_owner) + k) % 3);
         if (!found && req[cand]) begin
            rr_winner = cand;
            found     = 1'b1;
         end
      end
   end

`ifdef LED_BANK_ARBITER_PRIORITY_EN
   assign winner = req[0] ? 2'd0 : rr_winner;
`else
   assign winner = rr_winner;
`endif

   always_comb begin
      owner_mask     = onehot(last_owner);
      others         = req & ~owner_mask;
      owner_pattern  = pick_pattern(last_owner, pattern0, pattern1, pattern2);
      winner_pattern = pick_pattern(winner, pattern0, pattern1, pattern2);
      leave          = ((req & owner_mask) == 3'b000)
                     | ((count == COUNT_LAST) & (|others))
                     | (skip_re & (|others));
`ifdef LED_BANK_ARBITER_PRIORITY_EN
      if (req[0] && last_owner != 2'd0)
         leave = 1'b1;
`endif
   end

   // IDLE and SWITCH share the same arbitration step; SWITCH only differs by having blanked outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         led        <= '0;
         busy       <= 1'b0;
         count      <= '0;
         last_owner <= 2'd2;
      end else begin
         case (state)
            GRANT: begin
               if (leave) begin
                  state <= SWITCH;
                  grant <= '0;
                  led   <= '0;
                  busy  <= 1'b0;
                  count <= '0;
               end else begin
                  led   <= owner_pattern;
                  count <= (count == COUNT_LAST) ? '0 : count + 26'd1;
               end
            end
            default: begin
               if (|req) begin
                  state      <= GRANT;
                  last_owner <= winner;
                  count      <= '0;
                  grant      <= onehot(winner);
                  led        <= winner_pattern;
                  busy       <= 1'b1;
               end else begin
                  state <= IDLE;
                  grant <= '0;
                  led   <= '0;
                  busy  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter with DWELL_CYCLES=8; expectations come from a queue scoreboard.
// Honours LED_BANK_ARBITER_PRIORITY_EN for the policy-dependent sequences.
module tb_led_bank_arbiter;

   localparam logic [4:0] P0 = 5'b10101;
   localparam logic [4:0] P1 = 5'b01010;
   localparam logic [4:0] P2 = 5'b11100;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req;
   logic [4:0] pattern0, pattern1, pattern2;
   logic       skip_re;
   logic [2:0] grant;
   logic [4:0] led;
   logic       busy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   typedef struct {
      logic       rst;
      logic [2:0] rq;
      logic [4:0] p0;
      logic       sk;
      logic [2:0] eg;
      logic [4:0] el;
      logic       eb;
   } vec_t;

   typedef struct {
      string      name;
      logic [2:0] eg;
      logic [4:0] el;
      logic       eb;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   led_bank_arbiter #(.DWELL_CYCLES(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .pattern0 (pattern0),
      .pattern1 (pattern1),
      .pattern2 (pattern2),
      .skip_re  (skip_re),
      .grant    (grant),
      .led      (led),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required below 200000", $time);
      $fatal(1);
   end

   task automatic step(input string name, input logic r, input logic [2:0] rq, input logic [4:0] p0v,
                       input logic sk, input logic [2:0] eg, input logic [4:0] el, input logic eb);
      exp_t e;
      reset    = r;
      req      = rq;
      pattern0 = p0v;
      skip_re  = sk;
      e.name = name; e.eg = eg; e.el = el; e.eb = eb;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (grant !== e.eg || led !== e.el || busy !== e.eb) begin
         n_fail++;
         $display("FAIL %s: got grant=%b led=%b busy=%b, expected grant=%b led=%b busy=%b",
                  e.name, grant, led, busy, e.eg, e.el, e.eb);
      end
   endtask

   function automatic vec_t mk(logic r, logic [2:0] rq, logic [4:0] p0v, logic sk,
                               logic [2:0] eg, logic [4:0] el, logic eb);
      vec_t v;
      v.rst = r; v.rq = rq; v.p0 = p0v; v.sk = sk; v.eg = eg; v.el = el; v.eb = eb;
      return v;
   endfunction

   initial begin
      logic [2:0] second_owner;
      logic [4:0] second_led;

      reset = 1'b1; req = '0; skip_re = 1'b0;
      pattern0 = P0; pattern1 = P1; pattern2 = P2;

      // Basic single-requester behaviour, counter wrap, pattern tracking, skip/IDLE handling.
      tbl.push_back(mk(1, 3'b000, P0, 0, 3'b000, 5'b00000, 0));
      tbl.push_back(mk(1, 3'b111, P0, 1, 3'b000, 5'b00000, 0));
      tbl.push_back(mk(0, 3'b001, P0, 0, 3'b001, P0, 1));
      for (int i = 0; i < 10; i++)
         tbl.push_back(mk(0, 3'b001, P0, 0, 3'b001, P0, 1));
      tbl.push_back(mk(0, 3'b001, P0, 1, 3'b001, P0, 1));
      tbl.push_back(mk(0, 3'b001, 5'b11111, 0, 3'b001, 5'b11111, 1));
      tbl.push_back(mk(0, 3'b000, 5'b11111, 0, 3'b000, 5'b00000, 0));
      tbl.push_back(mk(0, 3'b000, P0, 0, 3'b000, 5'b00000, 0));
      tbl.push_back(mk(0, 3'b000, P0, 1, 3'b000, 5'b00000, 0));
      tbl.push_back(mk(0, 3'b010, P0, 0, 3'b010, P1, 1));
      tbl.push_back(mk(0, 3'b010, P0, 0, 3'b010, P1, 1));
      tbl.push_back(mk(0, 3'b000, P0, 0, 3'b000, 5'b00000, 0));
      foreach (tbl[i])
         step($sformatf("table[%0d]", i), tbl[i].rst, tbl[i].rq, tbl[i].p0, tbl[i].sk,
              tbl[i].eg, tbl[i].el, tbl[i].eb);

`ifdef LED_BANK_ARBITER_PRIORITY_EN
      second_owner = 3'b001; second_led = P0;
`else
      second_owner = 3'b010; second_led = P1;
`endif

      // Two requesters time-slicing with a blank cycle between slices.
      step("rr_reset", 1, 3'b011, P0, 0, 3'b000, 5'b00000, 0);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (r == 1) step($sformatf("rr_slice%0d_c%0d", r, c), 0, 3'b011, P0, 0, second_owner, second_led, 1);
            else        step($sformatf("rr_slice%0d_c%0d", r, c), 0, 3'b011, P0, 0, 3'b001, P0, 1);
         end
         step($sformatf("rr_blank%0d", r), 0, 3'b011, P0, 0, 3'b000, 5'b00000, 0);
      end

      // Owner 1 drops its request with requester 2 pending; last_owner must become 2.
      step("drop_reset", 1, 3'b000, P0, 0, 3'b000, 5'b00000, 0);
      step("drop_own1",  0, 3'b010, P0, 0, 3'b010, P1, 1);
      step("drop_own1b", 0, 3'b110, P0, 0, 3'b010, P1, 1);
      step("drop_switch", 0, 3'b100, P0, 0, 3'b000, 5'b00000, 0);
      step("drop_own2",  0, 3'b100, P0, 0, 3'b100, P2, 1);
      step("drop_sw2",   0, 3'b011, P0, 0, 3'b000, 5'b00000, 0);
      step("drop_after_last2", 0, 3'b011, P0, 0, 3'b001, P0, 1);

      // skip_re with a competitor at count 3 forces hand-over.
      step("skip_reset", 1, 3'b000, P0, 0, 3'b000, 5'b00000, 0);
      for (int c = 0; c < 4; c++)
         step($sformatf("skip_c%0d", c), 0, 3'b011, P0, 0, 3'b001, P0, 1);
      step("skip_switch", 0, 3'b011, P0, 1, 3'b000, 5'b00000, 0);
      step("skip_next",   0, 3'b011, P0, 0, second_owner, second_led, 1);

      // skip_re alone leaves the slice and its counter untouched.
      step("soloskip_reset", 1, 3'b000, P0, 0, 3'b000, 5'b00000, 0);
      step("soloskip_c0",    0, 3'b001, P0, 0, 3'b001, P0, 1);
      step("soloskip_c1",    0, 3'b001, P0, 1, 3'b001, P0, 1);
      for (int c = 2; c < 8; c++)
         step($sformatf("soloskip_c%0d", c), 0, 3'b011, P0, 0, 3'b001, P0, 1);
      step("soloskip_wrapsw", 0, 3'b011, P0, 0, 3'b000, 5'b00000, 0);

      // Reset mid-GRANT dominates; requester 0 wins first afterwards.
      step("rst_reset", 1, 3'b000, P0, 0, 3'b000, 5'b00000, 0);
      step("rst_own2",  0, 3'b100, P0, 0, 3'b100, P2, 1);
      step("rst_own2b", 0, 3'b100, P0, 0, 3'b100, P2, 1);
      step("rst_mid",   1, 3'b111, P0, 1, 3'b000, 5'b00000, 0);
      step("rst_after", 0, 3'b111, P0, 0, 3'b001, P0, 1);

      // Requester 0 appears while requester 2 owns the bank at count 1.
      step("pre_reset", 1, 3'b000, P0, 0, 3'b000, 5'b00000, 0);
      step("pre_c0",    0, 3'b100, P0, 0, 3'b100, P2, 1);
      step("pre_c1",    0, 3'b100, P0, 0, 3'b100, P2, 1);
`ifdef LED_BANK_ARBITER_PRIORITY_EN
      step("pre_switch", 0, 3'b101, P0, 0, 3'b000, 5'b00000, 0);
`else
      for (int c = 2; c < 8; c++)
         step($sformatf("pre_c%0d", c), 0, 3'b101, P0, 0, 3'b100, P2, 1);
      step("pre_switch", 0, 3'b101, P0, 0, 3'b000, 5'b00000, 0);
`endif
      step("pre_own0",  0, 3'b101, P0, 0, 3'b001, P0, 1);

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
